// File: rtl/truth_table_extractor.sv
// ============================================================================
//  Module      : truth_table_extractor
//  Description : Sweeps a 3-input combinational gate through its eight input
//                rows, samples its output after a settle interval per row,
//                assembles the 8-bit truth-table code (row r -> code[7-r]) and
//                compares it against a latched expected code.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module truth_table_extractor #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] expected,
    input  logic       dut_out,
    output logic       drive_in1,
    output logic       drive_in2,
    output logic       drive_in3,
    output logic       busy,
    output logic       done,
    output logic [7:0] code,
    output logic       match,
    output logic [2:0] first_fail_row
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    // Counter value on which the current row is sampled
    localparam logic [7:0] LAST_CNT  = 8'(SETTLE_CYCLES - 1);

    logic [1:0] state;
    logic [1:0] state_next;
    logic [2:0] row;
    logic [7:0] settle_cnt;
    logic [7:0] shadow;
    logic [7:0] expected_q;

    logic       last_tick;
    logic       sweep_end;
    logic [7:0] sweep_code;
    logic [7:0] diff_bits;
    logic [2:0] fail_row;

    assign last_tick  = (state == ST_SETTLE) && (settle_cnt == LAST_CNT);
    assign sweep_end  = last_tick && (row == 3'd7);
    // Row 7 lands in bit 0 on the very edge the result is published, so the
    // final code takes that bit straight from dut_out rather than the shadow.
    assign sweep_code = {shadow[7:1], dut_out};
    assign diff_bits  = sweep_code ^ expected_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start)     state_next = ST_SETTLE;
            ST_SETTLE: if (sweep_end) state_next = ST_DONE;
            ST_DONE:                  state_next = ST_IDLE;
            default:                  state_next = ST_IDLE;
        endcase
    end

    // Row/settle counters, expected latch and per-row sample capture
    always_ff @(posedge clk) begin
        if (reset) begin
            row        <= 3'd0;
            settle_cnt <= 8'd0;
            shadow     <= 8'd0;
            expected_q <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        expected_q <= expected;
                        row        <= 3'd0;
                        settle_cnt <= 8'd0;
                    end
                end
                ST_SETTLE: begin
                    if (last_tick) begin
                        shadow[3'd7 - row] <= dut_out;
                        settle_cnt         <= 8'd0;
                        if (row != 3'd7) begin
                            row <= row + 3'd1;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Lowest row whose measured bit disagrees with the expected code
    always_comb begin
        fail_row = 3'd0;
        for (int r = 7; r >= 0; r--) begin
            if (diff_bits[3'(7 - r)]) begin
                fail_row = 3'(r);
            end
        end
    end

    // Published result, updated on the edge entering DONE and held afterwards
    always_ff @(posedge clk) begin
        if (reset) begin
            code           <= 8'h00;
            match          <= 1'b0;
            first_fail_row <= 3'd0;
        end else if (sweep_end) begin
            code           <= sweep_code;
            match          <= (diff_bits == 8'h00);
            first_fail_row <= fail_row;
        end
    end

    // Outputs decoded from the registered state and row
    always_comb begin
        busy      = (state == ST_SETTLE);
        done      = (state == ST_DONE);
        drive_in1 = 1'b0;
        drive_in2 = 1'b0;
        drive_in3 = 1'b0;
        if (state == ST_SETTLE) begin
            drive_in1 = row[2];
            drive_in2 = row[1];
            drive_in3 = row[0];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_truth_table_extractor.sv
// ============================================================================
//  Module      : tb_truth_table_extractor
//  Description : Directed, table-driven bench for truth_table_extractor with
//                a behavioural gate model (programmable table, 0 or 3 cycle
//                input lag) on a SETTLE_CYCLES=4 instance and a lagging gate
//                on a SETTLE_CYCLES=2 instance.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_truth_table_extractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;

    // ---------------- instance A: SETTLE_CYCLES = 4 -----------------------
    logic       start_a = 1'b0;
    logic [7:0] exp_a   = 8'h00;
    logic       out_a;
    logic       d1_a, d2_a, d3_a, busy_a, done_a, match_a;
    logic [7:0] code_a;
    logic [2:0] ffr_a;

    truth_table_extractor #(.SETTLE_CYCLES(4)) u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .expected(exp_a),
        .dut_out(out_a), .drive_in1(d1_a), .drive_in2(d2_a), .drive_in3(d3_a),
        .busy(busy_a), .done(done_a), .code(code_a), .match(match_a),
        .first_fail_row(ffr_a)
    );

    // ---------------- instance B: SETTLE_CYCLES = 2 -----------------------
    logic       start_b = 1'b0;
    logic [7:0] exp_b   = 8'hBA;
    logic       out_b;
    logic       d1_b, d2_b, d3_b, busy_b, done_b, match_b;
    logic [7:0] code_b;
    logic [2:0] ffr_b;

    truth_table_extractor #(.SETTLE_CYCLES(2)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .expected(exp_b),
        .dut_out(out_b), .drive_in1(d1_b), .drive_in2(d2_b), .drive_in3(d3_b),
        .busy(busy_b), .done(done_b), .code(code_b), .match(match_b),
        .first_fail_row(ffr_b)
    );

    // ---------------- gate models -----------------------------------------
    logic [7:0] tt_a  = 8'hBA;
    logic       lag_a = 1'b0;
    logic [2:0] drv_a, drv_b;
    logic [2:0] a_p1 = 3'd0, a_p2 = 3'd0, a_p3 = 3'd0;
    logic [2:0] b_p1 = 3'd0, b_p2 = 3'd0, b_p3 = 3'd0;
    logic [7:0] tt_b  = 8'hBA;

    assign drv_a = {d1_a, d2_a, d3_a};
    assign drv_b = {d1_b, d2_b, d3_b};

    always @(posedge clk) begin
        a_p1 <= drv_a; a_p2 <= a_p1; a_p3 <= a_p2;
        b_p1 <= drv_b; b_p2 <= b_p1; b_p3 <= b_p2;
    end

    assign out_a = lag_a ? tt_a[7 - a_p3] : tt_a[7 - drv_a];
    assign out_b = tt_b[7 - b_p3];

    // ---------------- checking ---------------------------------------------
    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    typedef struct {
        logic [7:0] tt;
        logic       lag;
        logic [7:0] exp_code_in;
        logic       poke;
        logic [7:0] want_code;
        logic       want_match;
        logic [2:0] want_ffr;
    } vec_t;

    vec_t vecs[8];

    // One full sweep on instance A with per-cycle busy and drive checks
    task automatic run_sweep(input vec_t v, input string name);
        int  busy_cnt = 0;
        bit  drive_ok = 1;
        bit  got_done = 0;
        @(negedge clk);
        tt_a = v.tt; lag_a = v.lag; exp_a = v.exp_code_in; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int c = 0; c < 200 && !got_done; c++) begin
            if (done_a) begin
                got_done = 1;
            end else begin
                if (busy_a) begin
                    if (drv_a !== 3'(busy_cnt / 4)) drive_ok = 0;
                    busy_cnt++;
                end
                if (v.poke && busy_cnt == 10) begin
                    start_a = 1'b1; exp_a = ~v.exp_code_in;
                end else if (v.poke && busy_cnt == 11) begin
                    start_a = 1'b0;
                end
                @(negedge clk);
            end
        end
        start_a = 1'b0;
        check({name, " done seen"}, 32'(got_done), 32'd1);
        check({name, " busy cycles"}, busy_cnt, 32'd32);
        check({name, " drive sequence"}, 32'(drive_ok), 32'd1);
        check({name, " busy low at done"}, 32'(busy_a), 32'd0);
        check({name, " code"}, 32'(code_a), 32'(v.want_code));
        check({name, " match"}, 32'(match_a), 32'(v.want_match));
        check({name, " first_fail_row"}, 32'(ffr_a), 32'(v.want_ffr));
        @(negedge clk);
        check({name, " done single pulse"}, 32'(done_a), 32'd0);
        check({name, " code held"}, 32'(code_a), 32'(v.want_code));
    endtask

    initial begin
        int cnt;
        bit seen;

        //            tt     lag   exp    poke  code   match ffr
        vecs[0] = '{8'hBA, 1'b0, 8'hBA, 1'b0, 8'hBA, 1'b1, 3'd0};
        vecs[1] = '{8'h00, 1'b0, 8'hBA, 1'b0, 8'h00, 1'b0, 3'd0};
        vecs[2] = '{8'hBE, 1'b0, 8'hBA, 1'b0, 8'hBE, 1'b0, 3'd5};
        vecs[3] = '{8'hBA, 1'b1, 8'hBA, 1'b0, 8'hBA, 1'b1, 3'd0};
        vecs[4] = '{8'h96, 1'b0, 8'h69, 1'b0, 8'h96, 1'b0, 3'd0};
        vecs[5] = '{8'hFF, 1'b0, 8'hFE, 1'b0, 8'hFF, 1'b0, 3'd7};
        vecs[6] = '{8'h80, 1'b0, 8'h80, 1'b0, 8'h80, 1'b1, 3'd0};
        vecs[7] = '{8'hBA, 1'b0, 8'hBA, 1'b1, 8'hBA, 1'b1, 3'd0};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset busy",  32'(busy_a), 32'd0);
        check("reset done",  32'(done_a), 32'd0);
        check("reset drive", 32'(drv_a),  32'd0);
        check("reset code",  32'(code_a), 32'd0);
        check("reset match", 32'(match_a), 32'd0);
        check("reset ffr",   32'(ffr_a),  32'd0);

        foreach (vecs[i]) run_sweep(vecs[i], $sformatf("vec%0d", i));

        // Lagging gate against a too-short settle: row r samples row r-1
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        cnt = 0; seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            if (done_b) seen = 1;
            else begin
                if (busy_b) cnt++;
                @(negedge clk);
            end
        end
        check("short settle done seen", 32'(seen), 32'd1);
        check("short settle busy cycles", cnt, 32'd16);
        check("short settle code", 32'(code_b), 32'hDD);
        check("short settle match", 32'(match_b), 32'd0);
        check("short settle ffr", 32'(ffr_b), 32'd1);

        // Reset during row 4 aborts the sweep without a done
        @(negedge clk);
        tt_a = 8'hBA; lag_a = 1'b0; exp_a = 8'hBA; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            if (busy_a && drv_a == 3'd4) seen = 1;
            else @(negedge clk);
        end
        check("reached row 4", 32'(seen), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort busy",  32'(busy_a), 32'd0);
        check("abort drive", 32'(drv_a),  32'd0);
        check("abort code",  32'(code_a), 32'd0);
        check("abort match", 32'(match_a), 32'd0);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (done_a || busy_a) seen = 1;
            @(negedge clk);
        end
        check("no done after abort", 32'(seen), 32'd0);
        run_sweep(vecs[0], "post-abort");

        // start held high: back-to-back sweeps with one idle cycle between
        tt_a = 8'h96; exp_a = 8'h96; start_a = 1'b1;
        seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (done_a) seen = 1;
        end
        check("b2b first done", 32'(seen), 32'd1);
        check("b2b first code", 32'(code_a), 32'h96);
        @(negedge clk);
        check("b2b idle gap busy", 32'(busy_a), 32'd0);
        check("b2b idle gap done", 32'(done_a), 32'd0);
        @(negedge clk);
        check("b2b second busy", 32'(busy_a), 32'd1);
        start_a = 1'b0;
        tt_a = 8'h00;
        @(negedge clk);
        check("b2b previous code held", 32'(code_a), 32'h96);
        check("b2b previous match held", 32'(match_a), 32'd1);
        tt_a = 8'h96;
        seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (done_a) seen = 1;
        end
        check("b2b second done", 32'(seen), 32'd1);
        check("b2b second match", 32'(match_a), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
